// File: rtl/vec_store_serializer.sv
// Store serializer: merges scalar and 4-lane vector stores into one registered
// memory write per cycle, stalling the core while a vector burst drains.
module vec_store_serializer #(
    parameter int LANES  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          MemWrite,
    input  logic [ADDR_W-1:0]             DataAdr,
    input  logic [DATA_W-1:0]             WriteData,
    input  logic                          MemWriteVec,
    input  logic [LANES-1:0][ADDR_W-1:0]  DataAdrVec,
    input  logic [LANES-1:0][DATA_W-1:0]  WriteDataVec,
    output logic                          stall,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic                          err_misalign,
    output logic [15:0]                   wr_count
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_BURST    = 2'd1;
    localparam logic [1:0] ST_SCAL_VEC = 2'd2;

    localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    logic [1:0]                   state_q, state_d;
    logic [LANE_W-1:0]            lane_q, lane_d;
    logic [LANES-1:0][ADDR_W-1:0] abuf_q, abuf_d;
    logic [LANES-1:0][DATA_W-1:0] dbuf_q, dbuf_d;
    logic                         mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]            mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]            mem_wdata_q, mem_wdata_d;
    logic                         err_q, err_d;
    logic [15:0]                  cnt_q, cnt_d;

    logic                         issue_s;
    logic [ADDR_W-1:0]            issue_addr_s;
    logic [DATA_W-1:0]            issue_data_s;

    // Next-state, lane capture and write-issue selection.
    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        abuf_d       = abuf_q;
        dbuf_d       = dbuf_q;
        issue_s      = 1'b0;
        issue_addr_s = mem_addr_q;
        issue_data_s = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (MemWriteVec) begin
                    abuf_d = DataAdrVec;
                    dbuf_d = WriteDataVec;
                end else begin
                    abuf_d = abuf_q;
                    dbuf_d = dbuf_q;
                end

                // A scalar always goes first; a simultaneous vector waits one cycle.
                if (MemWrite) begin
                    issue_s      = 1'b1;
                    issue_addr_s = DataAdr;
                    issue_data_s = WriteData;
                    if (MemWriteVec) begin
                        state_d = ST_SCAL_VEC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (MemWriteVec) begin
                    issue_s      = 1'b1;
                    issue_addr_s = DataAdrVec[0];
                    issue_data_s = WriteDataVec[0];
                    state_d      = ST_BURST;
                    lane_d       = LANE_ONE;
                end else begin
                    issue_s = 1'b0;
                end
            end

            ST_BURST: begin
                issue_s      = 1'b1;
                issue_addr_s = abuf_q[lane_q];
                issue_data_s = dbuf_q[lane_q];
                if (lane_q == LAST_LANE) begin
                    state_d = ST_IDLE;
                    lane_d  = '0;
                end else begin
                    state_d = ST_BURST;
                    lane_d  = lane_q + LANE_ONE;
                end
            end

            ST_SCAL_VEC: begin
                issue_s      = 1'b1;
                issue_addr_s = abuf_q[0];
                issue_data_s = dbuf_q[0];
                state_d      = ST_BURST;
                lane_d       = LANE_ONE;
            end

            default: begin
                state_d = ST_IDLE;
                lane_d  = '0;
            end
        endcase

        mem_we_d    = issue_s;
        mem_addr_d  = issue_addr_s;
        mem_wdata_d = issue_data_s;

        if (issue_s) begin
            err_d = err_q | (issue_addr_s[1:0] != 2'b00);
            cnt_d = cnt_q + 16'd1;
        end else begin
            err_d = err_q;
            cnt_d = cnt_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            lane_q      <= '0;
            abuf_q      <= '0;
            dbuf_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
            cnt_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            abuf_q      <= abuf_d;
            dbuf_q      <= dbuf_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign stall        = (state_q != ST_IDLE);
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign err_misalign = err_q;
    assign wr_count     = cnt_q;

endmodule

// File: tb/tb_vec_store_serializer.sv
// Bench for vec_store_serializer: directed and random stores compared each
// cycle against a queue-based model of pending memory writes.
module tb_vec_store_serializer;

    localparam int LANES  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                         clk;
    logic                         reset;
    logic                         MemWrite;
    logic [ADDR_W-1:0]            DataAdr;
    logic [DATA_W-1:0]            WriteData;
    logic                         MemWriteVec;
    logic [LANES-1:0][ADDR_W-1:0] DataAdrVec;
    logic [LANES-1:0][DATA_W-1:0] WriteDataVec;
    logic                         stall;
    logic                         mem_we;
    logic [ADDR_W-1:0]            mem_addr;
    logic [DATA_W-1:0]            mem_wdata;
    logic                         err_misalign;
    logic [15:0]                  wr_count;

    int checks = 0;
    int errors = 0;

    // Model: writes still owed to memory, plus the expected output registers.
    logic [ADDR_W-1:0] q_addr[$];
    logic [DATA_W-1:0] q_data[$];
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic              m_err;
    logic [15:0]       m_cnt;

    int stall_cycles;
    int seen_30;

    vec_store_serializer #(
        .LANES (LANES),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .MemWrite    (MemWrite),
        .DataAdr     (DataAdr),
        .WriteData   (WriteData),
        .MemWriteVec (MemWriteVec),
        .DataAdrVec  (DataAdrVec),
        .WriteDataVec(WriteDataVec),
        .stall       (stall),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .err_misalign(err_misalign),
        .wr_count    (wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_addr.delete();
        q_data.delete();
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_err  = 1'b0;
        m_cnt  = 16'd0;
    endtask

    task automatic check_all();
        chk("stall",        64'(stall),        64'(q_addr.size() != 0));
        chk("mem_we",       64'(mem_we),       64'(m_we));
        chk("mem_addr",     64'(mem_addr),     64'(m_addr));
        chk("mem_wdata",    64'(mem_wdata),    64'(m_data));
        chk("err_misalign", 64'(err_misalign), 64'(m_err));
        chk("wr_count",     64'(wr_count),     64'(m_cnt));
    endtask

    // One clock: requests are only taken when nothing is owed; one write leaves per edge.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            if (q_addr.size() == 0) begin
                if (MemWrite) begin
                    q_addr.push_back(DataAdr);
                    q_data.push_back(WriteData);
                end
                if (MemWriteVec) begin
                    for (int i = 0; i < LANES; i++) begin
                        q_addr.push_back(DataAdrVec[i]);
                        q_data.push_back(WriteDataVec[i]);
                    end
                end
            end
            if (q_addr.size() != 0) begin
                m_we   = 1'b1;
                m_addr = q_addr.pop_front();
                m_data = q_data.pop_front();
                m_err  = m_err | (m_addr[1:0] != 2'b00);
                m_cnt  = m_cnt + 16'd1;
            end else begin
                m_we = 1'b0;
            end
        end
        #1;
        check_all();
        if (stall) stall_cycles++;
        if (mem_we && mem_addr == 32'h30) seen_30++;
    endtask

    task automatic set_vec_default();
        for (int i = 0; i < LANES; i++) begin
            DataAdrVec[i]   = 32'h100 + 32'(4 * i);
            WriteDataVec[i] = 32'hA + 32'(i);
        end
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        int guard;

        reset        = 1'b1;
        MemWrite     = 1'b0;
        DataAdr      = '0;
        WriteData    = '0;
        MemWriteVec  = 1'b0;
        DataAdrVec   = '0;
        WriteDataVec = '0;
        stall_cycles = 0;
        seen_30      = 0;
        model_reset();

        #12;
        chk("rst_stall",  64'(stall),        64'h0);
        chk("rst_we",     64'(mem_we),       64'h0);
        chk("rst_addr",   64'(mem_addr),     64'h0);
        chk("rst_wdata",  64'(mem_wdata),    64'h0);
        chk("rst_err",    64'(err_misalign), 64'h0);
        chk("rst_count",  64'(wr_count),     64'h0);
        #10;
        reset = 1'b0;

        // First scalar store
        MemWrite = 1'b1; DataAdr = 32'h64; WriteData = 32'h7;
        tick();
        MemWrite = 1'b0;
        chk("scalar_we",    64'(mem_we),    64'h1);
        chk("scalar_addr",  64'(mem_addr),  64'h64);
        chk("scalar_data",  64'(mem_wdata), 64'h7);
        chk("scalar_count", 64'(wr_count),  64'h1);
        tick();
        chk("idle_we", 64'(mem_we), 64'h0);

        // Vector store
        set_vec_default();
        MemWriteVec = 1'b1;
        stall_cycles = 0;
        tick();
        MemWriteVec = 1'b0;
        chk("vec_lane0_addr", 64'(mem_addr), 64'h100);
        for (int i = 0; i < 3; i++) tick();
        chk("vec_lane3_addr", 64'(mem_addr),  64'h10C);
        chk("vec_lane3_data", 64'(mem_wdata), 64'hD);
        chk("vec_stall_cyc",  64'(stall_cycles), 64'd3);
        chk("vec_count",      64'(wr_count), 64'd5);

        // Simultaneous scalar and vector
        MemWrite = 1'b1; DataAdr = 32'h20; WriteData = 32'h55;
        MemWriteVec = 1'b1;
        stall_cycles = 0;
        tick();
        MemWrite = 1'b0; MemWriteVec = 1'b0;
        chk("both_first_addr", 64'(mem_addr), 64'h20);
        tick();
        chk("both_lane0_addr", 64'(mem_addr), 64'h100);
        for (int i = 0; i < 3; i++) tick();
        chk("both_stall_cyc", 64'(stall_cycles), 64'd4);
        chk("both_count",     64'(wr_count), 64'd10);

        // Scalar held across a burst is written exactly once
        MemWriteVec = 1'b1;
        tick();
        MemWriteVec = 1'b0;
        MemWrite = 1'b1; DataAdr = 32'h30; WriteData = 32'h99;
        seen_30 = 0;
        for (int i = 0; i < 4; i++) tick();
        MemWrite = 1'b0;
        tick();
        tick();
        chk("held_once", 64'(seen_30), 64'd1);

        // Asynchronous reset mid-burst
        MemWriteVec = 1'b1;
        tick();
        MemWriteVec = 1'b0;
        tick();
        chk("mid_lane1_addr", 64'(mem_addr), 64'h104);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_we",    64'(mem_we),   64'h0);
        chk("async_stall", 64'(stall),    64'h0);
        chk("async_count", 64'(wr_count), 64'h0);
        tick();
        #4;
        reset = 1'b0;
        tick();
        tick();
        chk("post_rst_no_we", 64'(mem_we), 64'h0);
        MemWrite = 1'b1; DataAdr = 32'h44; WriteData = 32'h3;
        tick();
        MemWrite = 1'b0;
        chk("post_rst_addr",  64'(mem_addr), 64'h44);
        chk("post_rst_count", 64'(wr_count), 64'h1);

        // Misaligned scalar
        MemWrite = 1'b1; DataAdr = 32'h102; WriteData = 32'h1;
        tick();
        MemWrite = 1'b0;
        chk("mis_err",  64'(err_misalign), 64'h1);
        chk("mis_we",   64'(mem_we),       64'h1);
        chk("mis_addr", 64'(mem_addr),     64'h102);
        tick();
        chk("mis_sticky", 64'(err_misalign), 64'h1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            MemWrite    = 1'($urandom_range(0, 1));
            MemWriteVec = 1'($urandom_range(0, 1));
            a = $urandom();
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            DataAdr   = a;
            WriteData = $urandom();
            for (int i = 0; i < LANES; i++) begin
                a = $urandom();
                if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
                DataAdrVec[i]   = a;
                WriteDataVec[i] = $urandom();
            end
            tick();
        end
        MemWrite = 1'b0; MemWriteVec = 1'b0;
        tick();

        // Drive the write counter to its wrap point
        MemWrite = 1'b1;
        guard = 0;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            DataAdr   = {$urandom_range(0, 255), 2'b00};
            WriteData = $urandom();
            tick();
            guard++;
        end
        chk("wrap_pre", 64'(wr_count), 64'hFFFF);
        tick();
        MemWrite = 1'b0;
        chk("wrap_zero", 64'(wr_count), 64'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
